// File: rtl/aes_pkg.sv
// Shared key-loader definitions: key-size codes, words-per-key, FSM encoding
// and the one-hot key-length flag payload.
package aes_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned KEY_W  = 256;
    localparam int unsigned KS_W   = 2;
    localparam int unsigned WCNT_W = 4;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned NSLOTS = KEY_W / WORD_W;

    localparam logic [KS_W-1:0] KS_128 = 2'b00;
    localparam logic [KS_W-1:0] KS_192 = 2'b01;
    localparam logic [KS_W-1:0] KS_256 = 2'b10;
    localparam logic [KS_W-1:0] KS_ILL = 2'b11;

    localparam int unsigned NW_128 = 4;
    localparam int unsigned NW_192 = 6;
    localparam int unsigned NW_256 = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_ACK,
        ST_EXPAND,
        ST_READY
    } kl_state_e;

    typedef struct packed {
        logic len256;
        logic len192;
        logic len128;
    } klen_t;

    // Number of 32-bit words making up a key of the given size code.
    function automatic logic [WCNT_W-1:0] ks_words(input logic [KS_W-1:0] ks);
        case (ks)
            KS_128:  ks_words = WCNT_W'(NW_128);
            KS_192:  ks_words = WCNT_W'(NW_192);
            KS_256:  ks_words = WCNT_W'(NW_256);
            default: ks_words = '0;
        endcase
    endfunction

    function automatic klen_t ks_flags(input logic [KS_W-1:0] ks);
        klen_t f;
        f        = '0;
        f.len128 = (ks == KS_128);
        f.len192 = (ks == KS_192);
        f.len256 = (ks == KS_256);
        return f;
    endfunction

endpackage

// File: rtl/key_loader.sv
// Collects a 128/192/256-bit cipher key as 32-bit words, starts key expansion
// and tracks the repository handshake until round keys are available.
module key_loader
    import aes_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 4
) (
    input  logic              mclk,
    input  logic              arst,
    input  logic              key_wr_valid,
    output logic              key_wr_ready,
    input  logic [WORD_W-1:0] key_wr_data,
    input  logic [KS_W-1:0]   key_size,
    output logic [0:KEY_W-1]  cipherkey,
    output logic              keylength128,
    output logic              keylength192,
    output logic              keylength256,
    output logic              start_exp,
    input  logic              busy_exp,
    output logic              key_valid,
    output logic              key_err
);

    kl_state_e          r_state;
    kl_state_e          w_next_state;

    logic [0:KEY_W-1]   r_key;
    klen_t              r_flags;
    logic [WCNT_W-1:0]  r_nwords;
    logic [WCNT_W-1:0]  r_wcnt;
    logic [CNT_W-1:0]   r_tcnt;
    logic               r_ready;
    logic               r_start;
    logic               r_valid;
    logic               r_err;

    logic               w_accept;
    logic               w_legal;
    logic               w_first_load;
    logic               w_load_word;
    logic               w_err_set;
    logic               w_valid_next;
    logic               w_ready_next;
    logic               w_tcnt_clr;
    logic               w_tcnt_step;
    logic [WCNT_W-1:0]  w_wcnt_inc;
    logic [CNT_W-1:0]   w_tcnt_inc;
    logic [SLOT_W-1:0]  w_slot;

    assign w_accept   = key_wr_valid & r_ready;
    assign w_legal    = (key_size != KS_ILL);
    assign w_slot     = r_wcnt[SLOT_W-1:0];

    // Both counters saturate rather than wrap.
    assign w_wcnt_inc = (r_wcnt == '1) ? r_wcnt : r_wcnt + WCNT_W'(1);
    assign w_tcnt_inc = (r_tcnt == '1) ? r_tcnt : r_tcnt + CNT_W'(1);

    // Next-state and datapath control decode.
    always_comb begin
        w_next_state = r_state;
        w_first_load = 1'b0;
        w_load_word  = 1'b0;
        w_err_set    = 1'b0;
        w_valid_next = r_valid;
        w_tcnt_clr   = 1'b0;
        w_tcnt_step  = 1'b0;

        case (r_state)
            ST_IDLE, ST_READY: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_first_load = 1'b1;
                        w_valid_next = 1'b0;
                        w_next_state = ST_LOAD;
                    end else begin
                        w_err_set    = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_load_word = 1'b1;
                    if (w_wcnt_inc == r_nwords) begin
                        w_next_state = ST_START;
                    end
                end
            end
            ST_START: begin
                w_tcnt_clr   = 1'b1;
                w_next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (busy_exp) begin
                    w_next_state = ST_EXPAND;
                end else if (w_tcnt_inc == CNT_W'(ACK_TIMEOUT)) begin
                    w_err_set    = 1'b1;
                    w_valid_next = 1'b0;
                    w_next_state = ST_IDLE;
                end else begin
                    w_tcnt_step  = 1'b1;
                end
            end
            ST_EXPAND: begin
                if (!busy_exp) begin
                    w_valid_next = 1'b1;
                    w_next_state = ST_READY;
                end
            end
            default: begin
                w_valid_next = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_ready_next = (w_next_state == ST_IDLE) ||
                          (w_next_state == ST_LOAD) ||
                          (w_next_state == ST_READY);

    always_ff @(posedge mclk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Key assembly: a new load clears every slot so no bits of an older key survive.
    always_ff @(posedge mclk or posedge arst) begin
        if (arst) begin
            r_key    <= '0;
            r_flags  <= '0;
            r_nwords <= '0;
            r_wcnt   <= '0;
        end else if (w_first_load) begin
            r_key    <= {key_wr_data, (KEY_W-WORD_W)'(0)};
            r_flags  <= ks_flags(key_size);
            r_nwords <= ks_words(key_size);
            r_wcnt   <= WCNT_W'(1);
        end else if (w_load_word) begin
            for (int s = 0; s < NSLOTS; s++) begin
                if (w_slot == SLOT_W'(s)) begin
                    r_key[s*WORD_W +: WORD_W] <= key_wr_data;
                end
            end
            r_wcnt <= w_wcnt_inc;
        end
    end

    always_ff @(posedge mclk or posedge arst) begin
        if (arst) begin
            r_tcnt <= '0;
        end else if (w_tcnt_clr) begin
            r_tcnt <= '0;
        end else if (w_tcnt_step) begin
            r_tcnt <= w_tcnt_inc;
        end
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge mclk or posedge arst) begin
        if (arst) begin
            r_ready <= 1'b1;
            r_start <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_ready_next;
            r_start <= (w_next_state == ST_START);
            r_valid <= w_valid_next;
            r_err   <= w_err_set;
        end
    end

    assign key_wr_ready = r_ready;
    assign cipherkey    = r_key;
    assign keylength128 = r_flags.len128;
    assign keylength192 = r_flags.len192;
    assign keylength256 = r_flags.len256;
    assign start_exp    = r_start;
    assign key_valid    = r_valid;
    assign key_err      = r_err;

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: inputs change and outputs are checked on the
// falling clock edge, so every check sees the state left by the previous rising edge.
module tb_key_loader;

    logic         mclk = 1'b0;
    logic         arst;
    logic         key_wr_valid;
    logic         key_wr_ready;
    logic [31:0]  key_wr_data;
    logic [1:0]   key_size;
    logic [0:255] cipherkey;
    logic         keylength128;
    logic         keylength192;
    logic         keylength256;
    logic         start_exp;
    logic         busy_exp;
    logic         key_valid;
    logic         key_err;

    int checks = 0;
    int errors = 0;
    int waits;
    logic got;

    logic [31:0] w128 [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    logic [31:0] w192 [6] = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                              32'h62f8ead2, 32'h522c6b7b};
    logic [31:0] w256 [8] = '{32'h603deb10, 32'h15ca71be, 32'h2b73aeff, 32'h857d7781,
                              32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
    logic [31:0] wto  [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

    localparam logic [255:0] K128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aeff_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    localparam logic [255:0] KTO  = {128'h00112233_44556677_8899aabb_ccddeeff, 128'h0};
    localparam logic [255:0] K256_W0 = {32'h603deb10, 224'h0};

    key_loader #(.ACK_TIMEOUT(8), .CNT_W(4)) dut (
        .mclk         (mclk),
        .arst         (arst),
        .key_wr_valid (key_wr_valid),
        .key_wr_ready (key_wr_ready),
        .key_wr_data  (key_wr_data),
        .key_size     (key_size),
        .cipherkey    (cipherkey),
        .keylength128 (keylength128),
        .keylength192 (keylength192),
        .keylength256 (keylength256),
        .start_exp    (start_exp),
        .busy_exp     (busy_exp),
        .key_valid    (key_valid),
        .key_err      (key_err)
    );

    always #5 mclk = ~mclk;

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkf(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one word for exactly one rising edge; returns on the next falling edge.
    task automatic put(input logic [31:0] d, input logic [1:0] s);
        key_wr_valid = 1'b1;
        key_wr_data  = d;
        key_size     = s;
        @(negedge mclk);
    endtask

    // Model of key_repository: busy_exp high for hold cycles after start_exp (hold >= 2).
    task automatic expansion(input int hold);
        busy_exp = 1'b1;
        repeat (hold) @(negedge mclk);
        busy_exp = 1'b0;
        @(negedge mclk);
    endtask

    function automatic logic [2:0] flags();
        return {keylength256, keylength192, keylength128};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        arst         = 1'b1;
        key_wr_valid = 1'b0;
        key_wr_data  = '0;
        key_size     = 2'b00;
        busy_exp     = 1'b0;
        repeat (2) @(negedge mclk);
        arst = 1'b0;
        @(negedge mclk);

        chkb("rst_ready", key_wr_ready, 1'b1);
        chkk("rst_key", cipherkey, '0);
        chkf("rst_flags", flags(), 3'b000);
        chkb("rst_start", start_exp, 1'b0);
        chkb("rst_valid", key_valid, 1'b0);
        chkb("rst_err", key_err, 1'b0);

        // 128-bit back-to-back load
        for (int i = 0; i < 4; i++) put(w128[i], 2'b00);
        key_wr_valid = 1'b0;
        chkb("t1_start_hi", start_exp, 1'b1);
        chkb("t1_ready_start", key_wr_ready, 1'b0);
        chkk("t1_key", cipherkey, K128);
        chkf("t1_flags", flags(), 3'b001);
        busy_exp = 1'b1;
        @(negedge mclk);
        chkb("t1_start_one_cycle", start_exp, 1'b0);
        repeat (9) @(negedge mclk);
        chkb("t1_valid_busy", key_valid, 1'b0);
        chkb("t1_ready_busy", key_wr_ready, 1'b0);
        busy_exp = 1'b0;
        @(negedge mclk);
        chkb("t1_valid", key_valid, 1'b1);
        chkb("t1_ready", key_wr_ready, 1'b1);

        // 192-bit load from READY with a 3-cycle valid gap; size on word 1 must be ignored
        put(w192[0], 2'b01);
        chkb("t2_valid_drop", key_valid, 1'b0);
        put(w192[1], 2'b11);
        key_wr_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            @(negedge mclk);
            chkb("t2_gap_ready", key_wr_ready, 1'b1);
            chkb("t2_gap_start", start_exp, 1'b0);
        end
        for (int i = 2; i < 5; i++) put(w192[i], 2'b01);
        chkb("t2_no_early_start", start_exp, 1'b0);
        put(w192[5], 2'b01);
        key_wr_valid = 1'b0;
        chkb("t2_start_hi", start_exp, 1'b1);
        chkk("t2_key", cipherkey, K192);
        chkf("t2_flags", flags(), 3'b010);
        busy_exp = 1'b1;
        @(negedge mclk);
        chkb("t2_ready_wait", key_wr_ready, 1'b0);
        repeat (3) @(negedge mclk);
        chkb("t2_ready_expand", key_wr_ready, 1'b0);
        busy_exp = 1'b0;
        @(negedge mclk);
        chkb("t2_valid", key_valid, 1'b1);
        chkb("t2_ready", key_wr_ready, 1'b1);

        // 256-bit reload from READY; the first word must wipe the old key
        put(w256[0], 2'b10);
        chkb("t3_valid_drop", key_valid, 1'b0);
        chkk("t3_key_cleared", cipherkey, K256_W0);
        for (int i = 1; i < 8; i++) put(w256[i], 2'b10);
        key_wr_valid = 1'b0;
        chkb("t3_start_hi", start_exp, 1'b1);
        chkk("t3_key", cipherkey, K256);
        chkf("t3_flags", flags(), 3'b100);
        expansion(2);
        chkb("t3_valid", key_valid, 1'b1);

        // Illegal size while READY: error pulse, key and key_valid untouched
        put(32'hdeadbeef, 2'b11);
        key_wr_valid = 1'b0;
        chkb("t4r_err", key_err, 1'b1);
        chkb("t4r_valid_kept", key_valid, 1'b1);
        chkk("t4r_key_kept", cipherkey, K256);
        @(negedge mclk);
        chkb("t4r_err_pulse", key_err, 1'b0);

        // Illegal size from IDLE
        arst = 1'b1;
        @(negedge mclk);
        arst = 1'b0;
        @(negedge mclk);
        put(32'hdeadbeef, 2'b11);
        key_wr_valid = 1'b0;
        chkb("t4_err", key_err, 1'b1);
        chkk("t4_key_zero", cipherkey, '0);
        chkb("t4_ready", key_wr_ready, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge mclk);
            chkb("t4_no_start", start_exp, 1'b0);
            chkb("t4_err_pulse", key_err, 1'b0);
        end

        // ACK timeout: busy_exp never rises
        for (int i = 0; i < 4; i++) put(wto[i], 2'b00);
        key_wr_valid = 1'b0;
        chkb("t5_start_hi", start_exp, 1'b1);
        waits = 0;
        got   = 1'b0;
        while (!got && waits < 20) begin
            @(negedge mclk);
            if (key_err) got = 1'b1;
            else waits++;
        end
        chkb("t5_err_seen", got, 1'b1);
        chki("t5_wait_cycles", waits, 8);
        chkb("t5_valid", key_valid, 1'b0);
        chkf("t5_flags_kept", flags(), 3'b001);
        chkb("t5_ready", key_wr_ready, 1'b1);
        @(negedge mclk);
        chkb("t5_err_pulse", key_err, 1'b0);
        for (int i = 0; i < 4; i++) put(w128[i], 2'b00);
        key_wr_valid = 1'b0;
        chkb("t5_reload_start", start_exp, 1'b1);
        expansion(3);
        chkb("t5_reload_valid", key_valid, 1'b1);
        chkk("t5_reload_key", cipherkey, K128);

        // Asynchronous reset in the middle of LOAD
        put(wto[0], 2'b00);
        put(wto[1], 2'b00);
        key_wr_valid = 1'b0;
        #2 arst = 1'b1;
        #1;
        chkk("t6a_key", cipherkey, '0);
        chkf("t6a_flags", flags(), 3'b000);
        chkb("t6a_valid", key_valid, 1'b0);
        chkb("t6a_start", start_exp, 1'b0);
        @(negedge mclk);
        arst = 1'b0;
        @(negedge mclk);
        chkb("t6a_ready", key_wr_ready, 1'b1);

        // Asynchronous reset during EXPAND
        for (int i = 0; i < 4; i++) put(wto[i], 2'b00);
        key_wr_valid = 1'b0;
        busy_exp = 1'b1;
        repeat (3) @(negedge mclk);
        chkb("t6b_ready_expand", key_wr_ready, 1'b0);
        #2 arst = 1'b1;
        busy_exp = 1'b0;
        #1;
        chkk("t6b_key", cipherkey, '0);
        chkf("t6b_flags", flags(), 3'b000);
        chkb("t6b_valid", key_valid, 1'b0);
        chkb("t6b_err", key_err, 1'b0);
        @(negedge mclk);
        arst = 1'b0;
        @(negedge mclk);
        chkb("t6b_ready", key_wr_ready, 1'b1);

        // Fresh load after reset
        for (int i = 0; i < 4; i++) put(w128[i], 2'b00);
        key_wr_valid = 1'b0;
        chkb("t6c_start_hi", start_exp, 1'b1);
        chkk("t6c_key", cipherkey, K128);
        expansion(4);
        chkb("t6c_valid", key_valid, 1'b1);
        chkf("t6c_flags", flags(), 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
